merge_n_alu: RTL
================

# merge_n_alu

Clocked N-channel request/acknowledge merge in front of the ALU/memory execute stage. It takes N upstream four-phase req/ack channels, each carrying an opcode and payload, and decodes every opcode into a class (MEM or ALU). It keeps only the channels whose class is accepted on that channel, round-robin arbitrates among them, and forwards the winner over a single four-phase req/ack output. This is the parametrised successor of the two-input opcode-steered merge: channel count and width are configurable, the block has fair arbitration, it is fully synchronous, and illegal-opcode handling is optional.

## Interface
Parameters:
- N_CH, 2: number of input channels, 2..16.
- DATA_W, 32: payload width.
- CH_CLASS_MASK, {N_CH{2'b11}}: 2 bits per channel. Bit 0 means the channel accepts the MEM class; bit 1 means it accepts the ALU class.

Ports:
- clk  in  1  clock; the single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_i  in  N_CH  four-phase request, one per channel; already synchronous to clk.
- opcode_i  in  N_CH*7  opcode per channel; stable while that channel's req_i is high.
- data_i  in  N_CH*DATA_W  payload per channel; same stability rule as opcode_i.
- ack_o  out  N_CH  four-phase acknowledge per channel.
- req_o  out  1  downstream request.
- ack_i  in  1  downstream acknowledge.
- data_o  out  DATA_W  payload forwarded from the granted channel.
- opcode_o  out  7  opcode of the granted channel.
- ch_o  out  max(1,$clog2(N_CH))  index of the granted channel.
- err_o  out  1  illegal-opcode flag (see Configuration).

## Operation
- Class decode:
  - MEM: opcode 0000011 (load) or 0100011 (store).
  - ALU: opcode 0110011 (R), 0010011 (I-op) or 0000000 (NOP).
  - Any other opcode is ILLEGAL.
- A channel is eligible when req_i[c]=1, no ack_o[c] handshake is pending on it, and its decoded class bit is set in CH_CLASS_MASK[2c+:2].
- Arbitration is round-robin. Search starts at ptr and wraps modulo N_CH; the first eligible channel wins. After a grant to g, ptr = (g+1) mod N_CH.
- FSM states and transitions:
  - IDLE: if any channel is eligible, latch g, data_i[g] and opcode_i[g] into output registers; go to REQ.
  - REQ: req_o=1. On ack_i=1 go to HOLD.
  - HOLD: req_o=1, ack_o[g]=1. On req_i[g]=0 go to RTZ.
  - RTZ: req_o=0, ack_o[g]=1. On ack_i=0, drop ack_o[g] and go to IDLE.
- Only one ack_o bit is ever high at a time. data_o, opcode_o and ch_o hold their values from grant until the next grant.
- A channel whose class is masked out stalls indefinitely; this is a system-integration error and the block does not flag it.
- Reset values: state IDLE, ptr 0, req_o 0, ack_o all 0, data_o 0, opcode_o 0, ch_o 0, err_o 0.
- Reset mid-handshake aborts immediately to the reset values. Upstream and downstream must restart their protocols.

## Timing
- Grant latency: an eligible req_i seen at edge k in IDLE gives req_o=1 after edge k+1, with data_o valid in the same cycle.
- Each phase transition takes exactly one cycle after its condition is sampled. Minimum transaction length is 4 cycles, IDLE to IDLE.
- A back-to-back grant is possible in the cycle after returning to IDLE.
- Simultaneous requests are resolved in a single cycle by ptr; the losers wait and keep req_i high.
- ack_i rising while in IDLE or HOLD is ignored. Downstream protocol violations are not detected.

## Configuration
- MERGE_ILLEGAL_DROP_EN undefined:
  - ILLEGAL-class channels are never eligible and stall; err_o stays 0.
- MERGE_ILLEGAL_DROP_EN defined:
  - ILLEGAL-class channels are eligible only when no legal channel is eligible.
  - On grant, the FSM goes to a DROP state instead of REQ: req_o stays 0 and ack_o[g]=1 until req_i[g]=0, then returns to IDLE.
  - err_o pulses for 1 cycle at grant.
  - ptr advances as for a normal grant.

## Structure
- Package merge_pkg holds:
  - opcode constants: OP_R, OP_I_LD, OP_I_OP, OP_S, OP_NOP;
  - enum op_class_e {CLS_MEM, CLS_ALU, CLS_ILLEGAL};
  - the class-decode function;
  - the FSM state enum.
- One sub-module, rr_arbiter: N-bit eligible vector plus ptr in, one-hot grant and index out, purely combinational.

## Test plan
- N_CH=2, default mask, ch0 requests with load opcode 0000011, data 0xA5A5_0001 → req_o rises 1 cycle later with data_o=0xA5A5_0001 and ch_o=0; full four-phase completes in 4 cycles.
- N_CH=4, all four channels request ALU ops simultaneously and hold for 4 transactions → grant order 0,1,2,3, then ptr wraps to 0.
- CH_CLASS_MASK ch1=2'b01, ch1 issues R-type 0110011 → never granted, req_o stays 0; a concurrent ch0 store is granted normally.
- Without MERGE_ILLEGAL_DROP_EN, ch0 opcode 1111111 → no grant, err_o=0. With the macro → ack_o[0] asserted, req_o never rises, err_o pulses for 1 cycle.
- rst asserted in HOLD → next edge gives req_o=0, ack_o=0, ptr=0; a fresh request afterwards completes normally.
- ack_i held at 1 for 10 cycles in RTZ → ack_o[g] stays 1 and no new grant occurs until ack_i=0.

Source files
------------

// File: rtl/merge_pkg.sv
// Shared opcode constants, class decode and FSM state encoding for the
// request/acknowledge merge in front of the execute stage.
package merge_pkg;

    localparam int unsigned OP_W = 7;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I_LD = 7'b0000011;
    localparam logic [6:0] OP_I_OP = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_NOP  = 7'b0000000;

    typedef enum logic [1:0] {
        CLS_MEM     = 2'd0,
        CLS_ALU     = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_HOLD = 3'd2,
        ST_RTZ  = 3'd3,
        ST_DROP = 3'd4
    } merge_state_e;

    function automatic op_class_e decode_class(input logic [6:0] op);
        op_class_e cls;
        case (op)
            OP_I_LD, OP_S:         cls = CLS_MEM;
            OP_R, OP_I_OP, OP_NOP: cls = CLS_ALU;
            default:               cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Mask bit 0 admits MEM, bit 1 admits ALU; ILLEGAL is never admitted here
    function automatic logic class_accepted(input op_class_e cls, input logic [1:0] mask_bits);
        logic ok;
        case (cls)
            CLS_MEM: ok = mask_bits[0];
            CLS_ALU: ok = mask_bits[1];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first eligible channel at or after
// ptr (wrapping modulo N) wins.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N < 2) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam int SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] N_LIM = SUM_W'(N);

    logic [SUM_W-1:0] sum_s;
    logic [IDX_W-1:0] pos_s;

    // Walk offsets from farthest to nearest so the nearest eligible channel is written last
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum_s = '0;
        pos_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum_s = {1'b0, ptr} + SUM_W'(i);
            sum_s = (sum_s >= N_LIM) ? (sum_s - N_LIM) : sum_s;
            pos_s = sum_s[IDX_W-1:0];
            grant = elig[pos_s] ? ({{(N-1){1'b0}}, 1'b1} << pos_s) : grant;
            idx   = elig[pos_s] ? pos_s : idx;
            any   = any | elig[pos_s];
        end
    end

endmodule

// File: rtl/merge_n_alu.sv
// N-channel four-phase req/ack merge with opcode class filtering and
// round-robin arbitration. Optional feature macro: MERGE_ILLEGAL_DROP_EN.
module merge_n_alu
    import merge_pkg::*;
#(
    parameter int                N_CH          = 2,
    parameter int                DATA_W        = 32,
    parameter logic [2*N_CH-1:0] CH_CLASS_MASK = {N_CH{2'b11}},
    localparam int               CH_W          = (N_CH < 2) ? 1 : $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_i,
    input  logic [N_CH*7-1:0]        opcode_i,
    input  logic [N_CH*DATA_W-1:0]   data_i,
    output logic [N_CH-1:0]          ack_o,
    output logic                     req_o,
    input  logic                     ack_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [6:0]               opcode_o,
    output logic [CH_W-1:0]          ch_o,
    output logic                     err_o
);

    localparam logic [CH_W:0] PTR_LIM = (CH_W + 1)'(N_CH);

    merge_state_e        state_r, state_nxt_s;
    logic [CH_W-1:0]     ptr_r, ptr_nxt_s, ptr_wrap_s;
    logic [CH_W:0]       ptr_inc_s;
    logic [N_CH-1:0]     gnt_oh_r, gnt_oh_nxt_s;
    logic [N_CH-1:0]     ack_r, ack_nxt_s;
    logic                req_r, req_nxt_s;
    logic                err_r, err_nxt_s;
    logic [DATA_W-1:0]   data_r, data_nxt_s, data_sel_s;
    logic [6:0]          op_r, op_nxt_s, op_sel_s;
    logic [CH_W-1:0]     ch_r, ch_nxt_s;

    logic [N_CH-1:0]     legal_elig_s;
    logic [N_CH-1:0]     arb_elig_s;
    logic [N_CH-1:0]     arb_grant_s;
    logic [CH_W-1:0]     arb_idx_s;
    logic                arb_any_s;
    logic                gnt_req_low_s;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        op_class_e cls_s;
        assign cls_s           = decode_class(opcode_i[c*OP_W +: OP_W]);
        assign legal_elig_s[c] = req_i[c] & ~ack_r[c]
                               & class_accepted(cls_s, CH_CLASS_MASK[2*c +: 2]);
    end

`ifdef MERGE_ILLEGAL_DROP_EN
    logic [N_CH-1:0] illegal_elig_s;
    logic            drop_s;

    for (genvar c = 0; c < N_CH; c++) begin : g_ill
        assign illegal_elig_s[c] = req_i[c] & ~ack_r[c]
                                 & (decode_class(opcode_i[c*OP_W +: OP_W]) == CLS_ILLEGAL);
    end

    // Illegal requesters only compete when no legal channel is ready
    assign drop_s     = ~(|legal_elig_s);
    assign arb_elig_s = drop_s ? illegal_elig_s : legal_elig_s;
`else
    assign arb_elig_s = legal_elig_s;
`endif

    rr_arbiter #(.N(N_CH), .IDX_W(CH_W)) u_arb (
        .elig  (arb_elig_s),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    assign ptr_inc_s     = {1'b0, arb_idx_s} + {{CH_W{1'b0}}, 1'b1};
    assign ptr_wrap_s    = (ptr_inc_s == PTR_LIM) ? {CH_W{1'b0}} : ptr_inc_s[CH_W-1:0];
    assign gnt_req_low_s = ~(|(req_i & gnt_oh_r));

    // One-hot mux of the winning channel's payload and opcode
    always_comb begin
        data_sel_s = '0;
        op_sel_s   = '0;
        for (int c = 0; c < N_CH; c++) begin
            data_sel_s = data_sel_s | ({DATA_W{arb_grant_s[c]}} & data_i[c*DATA_W +: DATA_W]);
            op_sel_s   = op_sel_s   | ({OP_W{arb_grant_s[c]}} & opcode_i[c*OP_W +: OP_W]);
        end
    end

    // Next state plus the output values that the registers will present in that state
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        gnt_oh_nxt_s = gnt_oh_r;
        data_nxt_s   = data_r;
        op_nxt_s     = op_r;
        ch_nxt_s     = ch_r;
        req_nxt_s    = 1'b0;
        ack_nxt_s    = '0;
        err_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    ptr_nxt_s    = ptr_wrap_s;
                    gnt_oh_nxt_s = arb_grant_s;
                    data_nxt_s   = data_sel_s;
                    op_nxt_s     = op_sel_s;
                    ch_nxt_s     = arb_idx_s;
`ifdef MERGE_ILLEGAL_DROP_EN
                    if (drop_s) begin
                        state_nxt_s = ST_DROP;
                        ack_nxt_s   = arb_grant_s;
                        err_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_REQ;
                        req_nxt_s   = 1'b1;
                    end
`else
                    state_nxt_s = ST_REQ;
                    req_nxt_s   = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                req_nxt_s = 1'b1;
                if (ack_i) begin
                    state_nxt_s = ST_HOLD;
                    ack_nxt_s   = gnt_oh_r;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                ack_nxt_s = gnt_oh_r;
                if (gnt_req_low_s) begin
                    state_nxt_s = ST_RTZ;
                end else begin
                    state_nxt_s = ST_HOLD;
                    req_nxt_s   = 1'b1;
                end
            end
            ST_RTZ: begin
                if (!ack_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RTZ;
                    ack_nxt_s   = gnt_oh_r;
                end
            end
            ST_DROP: begin
                if (gnt_req_low_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                    ack_nxt_s   = gnt_oh_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            gnt_oh_r <= '0;
            ack_r    <= '0;
            req_r    <= 1'b0;
            err_r    <= 1'b0;
            data_r   <= '0;
            op_r     <= 7'd0;
            ch_r     <= '0;
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            gnt_oh_r <= gnt_oh_nxt_s;
            ack_r    <= ack_nxt_s;
            req_r    <= req_nxt_s;
            err_r    <= err_nxt_s;
            data_r   <= data_nxt_s;
            op_r     <= op_nxt_s;
            ch_r     <= ch_nxt_s;
        end
    end

    assign ack_o    = ack_r;
    assign req_o    = req_r;
    assign err_o    = err_r;
    assign data_o   = data_r;
    assign opcode_o = op_r;
    assign ch_o     = ch_r;

endmodule
